oserdes_playback_sequencer: RTL and testbench
=============================================

// Module: oserdes_playback_sequencer
// PURPOSE
//  Sequences the read side of the waveform BRAM feeding the 8-bit OSERDES function generator. SPI-written
//  registers set start/end address, loop count and trigger mode. The block then steps read_address once per
//  word_clock and asserts word_valid, aligned to BRAM read latency, so downstream logic can blank the lemo output
//  when idle. Sits between the ce0 SPI register slave and the BRAM port B, in the word_clock domain.
// PARAMETERS
//  ADDRESS_WIDTH   14  BRAM port-B word address width (4k x 32 bit = 16k x 8 bit words)
//  READ_LATENCY    1   BRAM port-B read latency in clocks; word_valid delay relative to read_address
//  REG_ADDR_WIDTH  4   register-file address width (low bits of SPI address16)
// PORTS
//  clock              in   1   word_clock; sole clock
//  reset              in   1   asynchronous, active-high
//  transaction_valid  in   1   one-cycle strobe from SPI slave: write data32 to register reg_address
//  reg_address        in   REG_ADDR_WIDTH  register select
//  data32             in   32  write data
//  read_data32        out  32  registered readback of register reg_address
//  trigger_in         in   1   asynchronous external trigger; rising edge used
//  read_address       out  ADDRESS_WIDTH  BRAM port-B address
//  word_valid         out  1   BRAM data_out word for this cycle belongs to an active playback
//  busy               out  1   state is ARMED or PLAYING
// BEHAVIOUR
//  Registers (R/W unless noted; reset value 0 except END = 2**ADDRESS_WIDTH-1):
//   0 CONTROL: [0] enable, [1] ext_trigger_en, [2] auto_rearm, [3] soft_trigger (self-clearing, reads 0)
//   1 START [ADDRESS_WIDTH-1:0]    2 END [ADDRESS_WIDTH-1:0]    3 LOOPS [15:0] (0 = infinite)
//   4 STATUS (RO): [1:0] state, [2] config_error, [31:16] loops_done.  Unmapped addresses read 0, writes ignored.
//  - read_data32 updates one clock after the reg_address change (registered mux).
//  - trigger_in: 2-FF synchroniser plus edge detect, so 3 clocks from pin to internal trigger pulse.
//  - trig = soft_trigger write | (ext_trigger_en & synchronised rising edge).
//  States: IDLE=0, ARMED=1, PLAYING=2, DONE=3.
//   IDLE    -> ARMED when enable=1. If END<START, set config_error and stay IDLE. config_error clears on any START/END write.
//   ARMED   -> PLAYING on trig. That same clock latches START/END/LOOPS into active copies, and read_address<=START.
//   PLAYING -> each clock: if read_address!=end_a, read_address+1.
//              Else it is a loop end: loops_done+1. If LOOPS!=0 and loops_done+1==loops_a, go to DONE; else read_address<=start_a.
//   DONE    -> ARMED if auto_rearm; otherwise hold until enable=0, then IDLE.
//   Any state -> IDLE on the clock after enable is written 0. loops_done is held for readback and cleared on ARMED->PLAYING.
//  - START==END: single-word loop, with one loop counted per clock.
//  - Register writes during PLAYING affect only the next arm (the active copies are shadowed).
//  - A trig in IDLE, PLAYING or DONE is ignored, and no trigger is queued.
//  - A write and a trigger arriving in the same clock: the write lands first, so the new values are latched.
//  - read_address holds its last value outside PLAYING; reset value 0.
//  - word_valid = (state==PLAYING) delayed by READ_LATENCY flops, so the last word of a DONE run is still flagged valid.
//  - Reset mid-play: all outputs and registers go to reset values immediately; word_valid=0, busy=0, read_data32=0.
// STRUCTURE
//  Shared package/header: state encodings, register address constants, CONTROL bit indices.
//  Natural sub-module: trigger_synchroniser (2-FF sync + rising-edge pulse), reusable elsewhere.
//  The register file, FSM and latency shift register stay in this module.
// TESTING
//  1. START=0x010, END=0x013, LOOPS=2, enable+soft_trigger -> addresses 10,11,12,13,10,11,12,13.
//     Then DONE, loops_done=2, word_valid high for exactly 8 clocks, lagging by READ_LATENCY.
//  2. LOOPS=0, START=END=0x005, ext trigger edge -> read_address constant 5 with word_valid high indefinitely;
//     writing enable=0 -> IDLE next clock, word_valid drops READ_LATENCY clocks later.
//  3. START=0x100, END=0x0FF, enable -> state stays IDLE, STATUS[2]=1; write END=0x1FF -> error clears, ARMED.
//  4. auto_rearm=1, LOOPS=1, two trigger_in pulses 50 clocks apart -> two identical bursts, state returns to ARMED between them.
//  5. During PLAYING write START=0x200 -> the current run is unchanged; the next burst starts at 0x200.
//  6. Assert reset during PLAYING -> read_address=0, busy=0, word_valid=0 at once; registers read back at reset values.

Source files
------------

// File: rtl/oserdes_playback_sequencer_pkg.sv
// Shared encodings for the OSERDES playback sequencer: FSM states, register map
// and CONTROL bit positions.
`timescale 1ns/1ps
package oserdes_playback_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PLAYING = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned REG_CONTROL = 0;
  localparam int unsigned REG_START   = 1;
  localparam int unsigned REG_END     = 2;
  localparam int unsigned REG_LOOPS   = 3;
  localparam int unsigned REG_STATUS  = 4;

  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_EXT_TRIG_EN = 1;
  localparam int unsigned CTRL_AUTO_REARM  = 2;
  localparam int unsigned CTRL_SOFT_TRIG   = 3;

  function automatic logic [31:0] status_word(input state_e st, input logic err,
                                               input logic [15:0] loops_done);
    return {loops_done, 13'd0, err, st};
  endfunction

endpackage

// File: rtl/oserdes_playback_sequencer_trigger_sync.sv
// Two-flop synchroniser for an asynchronous trigger pin followed by a registered
// rising-edge detector; pulse_o is one clock wide, three clocks after the pin rises.
`timescale 1ns/1ps
module oserdes_playback_sequencer_trigger_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       pulse_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], async_i};
      prev_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/oserdes_playback_sequencer.sv
// Read-side sequencer for the waveform BRAM: SPI register file, playback FSM and
// the word_valid latency pipe aligned to BRAM port-B read latency.
`timescale 1ns/1ps
module oserdes_playback_sequencer
  import oserdes_playback_sequencer_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 14,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      transaction_valid,
  input  logic [REG_ADDR_WIDTH-1:0] reg_address,
  input  logic [31:0]               data32,
  output logic [31:0]               read_data32,
  input  logic                      trigger_in,
  output logic [ADDRESS_WIDTH-1:0]  read_address,
  output logic                      word_valid,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  logic                     enable_q, ext_trig_en_q, auto_rearm_q;
  logic [ADDRESS_WIDTH-1:0] start_q, end_q;
  logic [15:0]              loops_q;

  logic                     wr_control, wr_start, wr_end, wr_loops;
  logic                     enable_eff, ext_trig_en_eff, auto_rearm_eff, soft_trig;
  logic [ADDRESS_WIDTH-1:0] start_eff, end_eff;
  logic [15:0]              loops_eff;
  logic                     ext_pulse, trig;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] start_a_q, start_a_d, end_a_q, end_a_d;
  logic [15:0]              loops_a_q, loops_a_d;
  logic [15:0]              loops_done_q, loops_done_d;
  logic                     config_error_q, config_error_d;

  logic [31:0]              rd_d, rd_q;
  logic [READ_LATENCY-1:0]  valid_pipe_q;
  logic                     unused_data_bits;

  assign wr_control = transaction_valid && (reg_address == REG_ADDR_WIDTH'(REG_CONTROL));
  assign wr_start   = transaction_valid && (reg_address == REG_ADDR_WIDTH'(REG_START));
  assign wr_end     = transaction_valid && (reg_address == REG_ADDR_WIDTH'(REG_END));
  assign wr_loops   = transaction_valid && (reg_address == REG_ADDR_WIDTH'(REG_LOOPS));

  // A write lands before anything else in the same clock, so the FSM sees the
  // freshly written values rather than the stored ones.
  assign enable_eff      = wr_control ? data32[CTRL_ENABLE]      : enable_q;
  assign ext_trig_en_eff = wr_control ? data32[CTRL_EXT_TRIG_EN] : ext_trig_en_q;
  assign auto_rearm_eff  = wr_control ? data32[CTRL_AUTO_REARM]  : auto_rearm_q;
  assign soft_trig       = wr_control & data32[CTRL_SOFT_TRIG];
  assign start_eff       = wr_start ? data32[ADDRESS_WIDTH-1:0] : start_q;
  assign end_eff         = wr_end   ? data32[ADDRESS_WIDTH-1:0] : end_q;
  assign loops_eff       = wr_loops ? data32[15:0]              : loops_q;
  assign unused_data_bits = ^data32[31:16];

  oserdes_playback_sequencer_trigger_sync u_trigger_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (trigger_in),
    .pulse_o (ext_pulse)
  );

  assign trig = soft_trig | (ext_trig_en_eff & ext_pulse);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q      <= 1'b0;
      ext_trig_en_q <= 1'b0;
      auto_rearm_q  <= 1'b0;
      start_q       <= '0;
      end_q         <= '1;
      loops_q       <= 16'd0;
    end else begin
      enable_q      <= enable_eff;
      ext_trig_en_q <= ext_trig_en_eff;
      auto_rearm_q  <= auto_rearm_eff;
      start_q       <= start_eff;
      end_q         <= end_eff;
      loops_q       <= loops_eff;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    start_a_d      = start_a_q;
    end_a_d        = end_a_q;
    loops_a_d      = loops_a_q;
    loops_done_d   = loops_done_q;
    config_error_d = config_error_q;
    if (wr_start || wr_end) begin
      config_error_d = 1'b0;
    end
    if (!enable_eff) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (end_eff < start_eff) begin
            config_error_d = 1'b1;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            state_d      = ST_PLAYING;
            start_a_d    = start_eff;
            end_a_d      = end_eff;
            loops_a_d    = loops_eff;
            addr_d       = start_eff;
            loops_done_d = 16'd0;
          end
        end
        ST_PLAYING: begin
          if (addr_q != end_a_q) begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
          end else begin
            // LOOPS == 0 never terminates; loops_done simply wraps.
            loops_done_d = loops_done_q + 16'd1;
            if ((loops_a_q != 16'd0) && (loops_done_d == loops_a_q)) begin
              state_d = ST_DONE;
            end else begin
              addr_d = start_a_q;
            end
          end
        end
        ST_DONE: begin
          if (auto_rearm_eff) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      start_a_q      <= '0;
      end_a_q        <= '0;
      loops_a_q      <= 16'd0;
      loops_done_q   <= 16'd0;
      config_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      start_a_q      <= start_a_d;
      end_a_q        <= end_a_d;
      loops_a_q      <= loops_a_d;
      loops_done_q   <= loops_done_d;
      config_error_q <= config_error_d;
    end
  end

  always_comb begin
    rd_d = 32'd0;
    case (reg_address)
      REG_ADDR_WIDTH'(REG_CONTROL): rd_d = {29'd0, auto_rearm_q, ext_trig_en_q, enable_q};
      REG_ADDR_WIDTH'(REG_START):   rd_d = 32'(start_q);
      REG_ADDR_WIDTH'(REG_END):     rd_d = 32'(end_q);
      REG_ADDR_WIDTH'(REG_LOOPS):   rd_d = {16'd0, loops_q};
      REG_ADDR_WIDTH'(REG_STATUS):  rd_d = status_word(state_q, config_error_q, loops_done_q);
      default:                      rd_d = 32'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q         <= 32'd0;
      valid_pipe_q <= '0;
    end else begin
      rd_q            <= rd_d;
      valid_pipe_q[0] <= (state_q == ST_PLAYING);
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_pipe_q[i] <= valid_pipe_q[i-1];
      end
    end
  end

  assign read_data32  = rd_q;
  assign read_address = addr_q;
  assign word_valid   = valid_pipe_q[READ_LATENCY-1];
  assign busy         = (state_q == ST_ARMED) || (state_q == ST_PLAYING);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_oserdes_playback_sequencer.sv
// Directed bench for oserdes_playback_sequencer: register access, soft/external
// triggers, loop counting, config error, shadowed registers and mid-play reset.
`timescale 1ns/1ps
module tb_oserdes_playback_sequencer;

  localparam int AW = 14;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_PLAY = 2'd2, S_DONE = 2'd3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          transaction_valid = 1'b0;
  logic [3:0]    reg_address = 4'd0;
  logic [31:0]   data32 = 32'd0;
  logic [31:0]   read_data32;
  logic          trigger_in = 1'b0;
  logic [AW-1:0] read_address;
  logic          word_valid;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  oserdes_playback_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .transaction_valid (transaction_valid),
    .reg_address       (reg_address),
    .data32            (data32),
    .read_data32       (read_data32),
    .trigger_in        (trigger_in),
    .read_address      (read_address),
    .word_valid        (word_valid),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write's posedge.
  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    transaction_valid = 1'b1;
    reg_address       = a;
    data32            = d;
    @(negedge clock);
    transaction_valid = 1'b0;
    data32            = 32'd0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    reg_address = a;
    @(negedge clock);
    check(tag, read_data32, exp);
  endtask

  // Pulse trigger_in and expect PLAYING exactly four negedges later.
  task automatic ext_trigger(input string tag);
    int n;
    n = 0;
    trigger_in = 1'b1;
    while (dbg_state !== S_PLAY && n < 20) begin
      @(negedge clock);
      n++;
      if (n == 2) trigger_in = 1'b0;
    end
    trigger_in = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic ext_burst(input string tag, input logic [AW-1:0] s);
    ext_trigger(tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_addr"}, 32'(read_address), 32'(s + AW'(i)));
      check({tag, "_wv"}, 32'(word_valid), 32'(i != 0));
      @(negedge clock);
    end
    check({tag, "_done"}, 32'(dbg_state), 32'(S_DONE));
    check({tag, "_wv_last"}, 32'(word_valid), 32'd1);
    @(negedge clock);
    check({tag, "_rearm"}, 32'(dbg_state), 32'(S_ARMED));
    check({tag, "_wv_off"}, 32'(word_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] exp_addr [8];
    logic [AW-1:0] tail [5];
    int wv_count;

    // ---------------- reset ----------------
    repeat (3) @(negedge clock);
    check("rst_addr", 32'(read_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wv", 32'(word_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    @(negedge clock);
    read_check("rst_end_reg", 4'd2, 32'h0000_3FFF);

    // ---------------- 1: soft trigger, 2 loops ----------------
    write_reg(4'd1, 32'h010);
    write_reg(4'd2, 32'h013);
    write_reg(4'd3, 32'd2);
    write_reg(4'd0, 32'h1);
    check("t1_armed", 32'(dbg_state), 32'(S_ARMED));
    check("t1_busy", 32'(busy), 32'd1);
    write_reg(4'd0, 32'h9);
    exp_addr = '{14'h10, 14'h11, 14'h12, 14'h13, 14'h10, 14'h11, 14'h12, 14'h13};
    wv_count = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        check("t1_addr", 32'(read_address), 32'(exp_addr[k]));
        check("t1_state", 32'(dbg_state), 32'(S_PLAY));
      end else begin
        check("t1_done", 32'(dbg_state), 32'(S_DONE));
      end
      check("t1_wv", 32'(word_valid), 32'((k >= 1) && (k <= 8)));
      if (word_valid === 1'b1) wv_count++;
      @(negedge clock);
    end
    check("t1_wv_count", 32'(wv_count), 32'd8);
    check("t1_hold_addr", 32'(read_address), 32'h13);
    read_check("t1_status", 4'd4, 32'h0002_0003);
    read_check("t1_ctrl_rb", 4'd0, 32'h1);

    // ---------------- 2: single-word infinite loop, ext trigger ----------------
    write_reg(4'd0, 32'h0);
    check("t2_idle", 32'(dbg_state), 32'(S_IDLE));
    write_reg(4'd3, 32'd0);
    write_reg(4'd1, 32'h005);
    write_reg(4'd2, 32'h005);
    write_reg(4'd0, 32'h3);
    check("t2_armed", 32'(dbg_state), 32'(S_ARMED));
    ext_trigger("t2");
    check("t2_first_addr", 32'(read_address), 32'h5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t2_addr", 32'(read_address), 32'h5);
      check("t2_wv", 32'(word_valid), 32'd1);
    end
    write_reg(4'd0, 32'h0);
    check("t2_stop_state", 32'(dbg_state), 32'(S_IDLE));
    check("t2_stop_busy", 32'(busy), 32'd0);
    check("t2_wv_lag", 32'(word_valid), 32'd1);
    check("t2_hold_addr", 32'(read_address), 32'h5);
    @(negedge clock);
    check("t2_wv_drop", 32'(word_valid), 32'd0);

    // ---------------- 3: END < START config error ----------------
    write_reg(4'd1, 32'h100);
    write_reg(4'd2, 32'h0FF);
    write_reg(4'd0, 32'h1);
    check("t3_stay_idle", 32'(dbg_state), 32'(S_IDLE));
    reg_address = 4'd4;
    @(negedge clock);
    check("t3_err_set", 32'(read_data32[2:0]), 32'h4);
    write_reg(4'd2, 32'h1FF);
    check("t3_armed", 32'(dbg_state), 32'(S_ARMED));
    reg_address = 4'd4;
    @(negedge clock);
    check("t3_err_clr", 32'(read_data32[2:0]), 32'h1);

    // ---------------- 4: auto re-arm, two external bursts ----------------
    write_reg(4'd1, 32'h020);
    write_reg(4'd2, 32'h023);
    write_reg(4'd3, 32'd1);
    write_reg(4'd0, 32'h7);
    check("t4_armed", 32'(dbg_state), 32'(S_ARMED));
    ext_burst("t4_b1", 14'h020);
    repeat (40) @(negedge clock);
    check("t4_between", 32'(dbg_state), 32'(S_ARMED));
    ext_burst("t4_b2", 14'h020);

    // ---------------- 5: START written while PLAYING is shadowed ----------------
    write_reg(4'd0, 32'h1);
    write_reg(4'd3, 32'd2);
    write_reg(4'd0, 32'h9);
    check("t5_a0", 32'(read_address), 32'h20);
    @(negedge clock);
    check("t5_a1", 32'(read_address), 32'h21);
    write_reg(4'd1, 32'h200);
    check("t5_a2", 32'(read_address), 32'h22);
    tail = '{14'h23, 14'h20, 14'h21, 14'h22, 14'h23};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_tail", 32'(read_address), 32'(tail[i]));
    end
    @(negedge clock);
    check("t5_done", 32'(dbg_state), 32'(S_DONE));
    check("t5_done_addr", 32'(read_address), 32'h23);
    write_reg(4'd2, 32'h203);
    write_reg(4'd0, 32'h0);
    write_reg(4'd0, 32'h1);
    check("t5_rearmed", 32'(dbg_state), 32'(S_ARMED));
    write_reg(4'd0, 32'h9);
    check("t5_new_start", 32'(read_address), 32'h200);
    @(negedge clock);
    check("t5_new_next", 32'(read_address), 32'h201);
    check("t5_new_wv", 32'(word_valid), 32'd1);

    // ---------------- 6: asynchronous reset mid-play ----------------
    reset = 1'b1;
    #1;
    check("t6_addr", 32'(read_address), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_wv", 32'(word_valid), 32'd0);
    check("t6_rdata", read_data32, 32'd0);
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clock);
    reset = 1'b0;
    write_reg(4'd9, 32'hFFFF_FFFF);
    read_check("t6_end_reg", 4'd2, 32'h0000_3FFF);
    read_check("t6_start_reg", 4'd1, 32'd0);
    read_check("t6_loops_reg", 4'd3, 32'd0);
    read_check("t6_ctrl_reg", 4'd0, 32'd0);
    read_check("t6_status_reg", 4'd4, 32'd0);
    read_check("t6_unmapped", 4'd9, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
